// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings of the supported access types
//   - FSM state encoding
//   - lsu_decode(): funct3 -> access size (log2 bytes), sign-extend flag, legality
package lsu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_D  = 3'b011;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [2:0] LS_WU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ADDR2 = 3'd3,
    ST_DATA2 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic       sext;
    logic [1:0] size;   // log2 of access size in bytes
  } lsu_acc_t;

  // wide = 1 when the bus is 64 bits, which enables D and WU.
  function automatic lsu_acc_t lsu_decode(input logic [2:0] funct3, input logic wide);
    lsu_acc_t a;
    a.legal = 1'b1;
    a.sext  = 1'b0;
    a.size  = 2'd0;
    case (funct3)
      LS_B:    begin a.sext = 1'b1; a.size = 2'd0; end
      LS_H:    begin a.sext = 1'b1; a.size = 2'd1; end
      LS_W:    begin a.sext = 1'b1; a.size = 2'd2; end
      LS_D:    begin a.size = 2'd3; a.legal = wide; end
      LS_BU:   a.size = 2'd0;
      LS_HU:   a.size = 2'd1;
      LS_WU:   begin a.size = 2'd2; a.legal = wide; end
      default: a.legal = 1'b0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response and data-memory bus signals of the LSU.
//   slave  : the LSU (consumes requests, drives the memory bus)
//   master : the environment (execute stage + memory)
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane shifter.
// Works on a two-word window so that an access crossing a bus word boundary
// yields the lanes of both beats: the low half belongs to the first (aligned)
// word, the high half to the following word.
//   size_i  : log2 access bytes        off_i   : byte offset in bus word
//   sext_i  : sign-extend loads        wdata_i : LSB-aligned store data
//   rdata_i : {second word, first word} raw read data
//   be_o    : byte enables, two words  wdata_o : store data on its lanes, two words
//   rdata_o : load data shifted down and extended
module lsu_align #(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                   size_i,
  input  logic                         sext_i,
  input  logic [$clog2(DATA_W/8)-1:0]  off_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [2*DATA_W-1:0]          rdata_i,
  output logic [2*DATA_W/8-1:0]        be_o,
  output logic [2*DATA_W-1:0]          wdata_o,
  output logic [DATA_W-1:0]            rdata_o
);
  localparam int BE_W = DATA_W / 8;

  int                  nbytes;
  logic [2*BE_W-1:0]   mask;
  logic [2*DATA_W-1:0] rshift;
  logic [DATA_W-1:0]   rword;
  logic                msb;
  logic                sbit;

  assign nbytes = 1 << size_i;

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2*BE_W; i++) mask[i] = (i < nbytes);
    be_o = mask << off_i;
  end

  assign wdata_o = {{DATA_W{1'b0}}, wdata_i} << {off_i, 3'b000};
  assign rshift  = rdata_i >> {off_i, 3'b000};
  assign rword   = rshift[DATA_W-1:0];

  always_comb begin
    case (size_i)
      2'd0:    msb = rword[7];
      2'd1:    msb = rword[15];
      default: msb = rword[31];
    endcase
    sbit    = msb & sext_i;
    rdata_o = rword;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= 8*nbytes) rdata_o[i] = sbit;
    end
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit between execute stage and data-memory bus.
// Ports: clk, rst_n (async, active low), bus (lsu_mem_ctrl_if.slave: core
// request/response handshake and memory req/gnt/rvalid bus).
// Build option: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned accesses that
// cross a bus word are split into two beats; otherwise every misaligned access
// is answered with resp_err and no bus cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | req_ready=1, waiting for a request
// ADDR     | mem_req held for first (or only) beat until mem_gnt
// DATA     | waiting for mem_rvalid of first beat
// ADDR2    | mem_req held for second beat (split access)
// DATA2    | waiting for mem_rvalid of second beat
// RESP     | resp_valid pulse with data/err
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst_n,
  lsu_mem_ctrl_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d, sext_q, sext_d, err_q, err_d, split_q, split_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rlo_q, rlo_d, rdata_q, rdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  lsu_acc_t            req_acc;
  logic [OFF_W-1:0]    req_off;
  logic                req_bad, req_split, tmo_hit;
  logic [ADDR_W-1:0]   addr_aligned;
  logic [2*BE_W-1:0]   be_both;
  logic [2*DATA_W-1:0] wdata_both, rdata_both;
  logic [DATA_W-1:0]   rdata_ext;

  assign req_acc = lsu_decode(bus.req_funct3, DATA_W == 64);
  assign req_off = bus.req_addr[OFF_W-1:0];

`ifdef LSU_MISALIGN_SPLIT_EN
  // Only an access running past the end of the bus word needs a second beat.
  assign req_split = (32'(req_off) + (32'd1 << req_acc.size)) > 32'(BE_W);
  assign req_bad   = !req_acc.legal;
`else
  logic req_mis;
  assign req_mis   = (req_off & OFF_W'((32'd1 << req_acc.size) - 32'd1)) != '0;
  assign req_split = 1'b0;
  assign req_bad   = !req_acc.legal || req_mis;
`endif

  assign tmo_hit      = (TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign addr_aligned = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign rdata_both   = (state_q == ST_DATA2) ? {bus.mem_rdata, rlo_q}
                                              : {{DATA_W{1'b0}}, bus.mem_rdata};

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size_i  (size_q),
    .sext_i  (sext_q),
    .off_i   (addr_q[OFF_W-1:0]),
    .wdata_i (wdata_q),
    .rdata_i (rdata_both),
    .be_o    (be_both),
    .wdata_o (wdata_both),
    .rdata_o (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      split_q <= split_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rlo_q   <= rlo_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sext_d  = sext_q;
    err_d   = err_q;
    split_d = split_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rlo_d   = rlo_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          sext_d  = req_acc.sext;
          size_d  = req_acc.size;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          split_d = req_split;
          err_d   = req_bad;
          rdata_d = '0;
          tmo_d   = '0;
          state_d = req_bad ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR, ST_ADDR2: begin
        if (bus.mem_gnt) begin
          tmo_d   = '0;
          state_d = (state_q == ST_ADDR) ? ST_DATA : ST_DATA2;
        end else if (tmo_hit) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DATA, ST_DATA2: begin
        if (bus.mem_rvalid) begin
          tmo_d = '0;
          if (state_q == ST_DATA && split_q) begin
            rlo_d   = bus.mem_rdata;
            state_d = ST_ADDR2;
          end else begin
            rdata_d = we_q ? '0 : rdata_ext;
            state_d = ST_RESP;
          end
        end else if (tmo_hit) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == ST_IDLE);
    bus.resp_valid = (state_q == ST_RESP);
    bus.resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    bus.resp_err   = (state_q == ST_RESP) & err_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      ST_ADDR: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_aligned;
        bus.mem_be    = be_both[BE_W-1:0];
        bus.mem_wdata = wdata_both[DATA_W-1:0];
      end
      ST_ADDR2: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_aligned + ADDR_W'(BE_W);
        bus.mem_be    = be_both[2*BE_W-1:BE_W];
        bus.mem_wdata = wdata_both[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } resp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;

  resp_t       exp_q[$];
  beat_t       beat_q[$];
  logic [31:0] mem_arr [bit [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          req_hi_cnt = 0;
  bit          gnt_en = 1'b1;
  bit          rv_en = 1'b1;
  string       tname = "reset";

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h, required 0x%08h", tname, name, act, exp);
    end
  endfunction

  // Memory model: grants while gnt_en, answers one cycle after the grant.
  initial begin
    beat_t       b;
    logic [31:0] rd, w, a;
    bit          pend;
    pend = 1'b0;
    rd = '0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) req_hi_cnt++;
      if (bus.mem_req && bus.mem_gnt) begin
        if (beat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s/unexpected_beat: got bus beat addr 0x%08h, required none", tname, bus.mem_addr);
        end else begin
          b = beat_q.pop_front();
          chk("beat_we", {31'b0, bus.mem_we}, {31'b0, b.we});
          chk("beat_addr", bus.mem_addr, b.addr);
          chk("beat_be", {28'b0, bus.mem_be}, {28'b0, b.be});
          if (b.we) chk("beat_wdata", bus.mem_wdata, b.wdata);
        end
        a = bus.mem_addr;
        if (bus.mem_we) begin
          w = mem_arr.exists(a) ? mem_arr[a] : 32'h0;
          for (int i = 0; i < 4; i++) if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
          mem_arr[a] = w;
          rd = '0;
        end else begin
          rd = mem_arr.exists(a) ? mem_arr[a] : 32'hDEAD_BEEF;
        end
        pend = 1'b1;
      end
      @(posedge clk); #1;
      bus.mem_rvalid = pend && rv_en;
      bus.mem_rdata  = (pend && rv_en) ? rd : 32'h0;
      pend = 1'b0;
      bus.mem_gnt = bus.mem_req && gnt_en;
    end
  end

  // Response monitor.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s/unexpected_resp: got resp_valid rdata 0x%08h, required none", tname, bus.resp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
          chk("resp_latency", cyc - e.acc, e.lat);
          @(negedge clk);
          chk("ready_after_resp", {31'b0, bus.req_ready}, 32'd1);
          chk("resp_pulse", {31'b0, bus.resp_valid}, 32'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  // exp_lat < 0: no response expected.
  task automatic issue(input string name, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    resp_t e;
    bit    ok;
    tname = name;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wd;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/accept: got req_ready 0 for 64 cycles, required 1", tname);
      bus.req_valid = 1'b0;
      return;
    end
    if (exp_lat >= 0) begin
      e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && beat_q.size() == 0 && bus.req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s/drain: got %0d responses and %0d beats pending, required 0", tname, exp_q.size(), beat_q.size());
      exp_q.delete();
      beat_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_be", {28'b0, bus.mem_be}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;

    mem_arr[32'h100] = 32'h8000_00F0;
    push_beat(1'b0, 32'h100, 4'hF, 32'h0);
    issue("lw", 1'b0, LS_W, 32'h100, 32'h0, 32'h8000_00F0, 1'b0, 3);
    drain();

    mem_arr[32'h100] = 32'h8012_3456;
    push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    issue("lb", 1'b0, LS_B, 32'h103, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
    drain();
    push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    issue("lbu", 1'b0, LS_BU, 32'h103, 32'h0, 32'h0000_0080, 1'b0, 3);
    drain();
    push_beat(1'b0, 32'h100, 4'b0001, 32'h0);
    issue("lb_pos", 1'b0, LS_B, 32'h100, 32'h0, 32'h0000_0056, 1'b0, 3);
    drain();

    mem_arr[32'h100] = 32'h8001_1234;
    push_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    issue("lhu", 1'b0, LS_HU, 32'h102, 32'h0, 32'h0000_8001, 1'b0, 3);
    drain();
    push_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    issue("lh", 1'b0, LS_H, 32'h102, 32'h0, 32'hFFFF_8001, 1'b0, 3);
    drain();

    push_beat(1'b1, 32'h100, 4'b0010, 32'h0000_AB00);
    issue("sb", 1'b1, LS_B, 32'h101, 32'h0000_00AB, 32'h0, 1'b0, 3);
    drain();
    push_beat(1'b1, 32'h100, 4'b1100, 32'hBEEF_0000);
    issue("sh", 1'b1, LS_H, 32'h102, 32'h0000_BEEF, 32'h0, 1'b0, 3);
    drain();
    push_beat(1'b0, 32'h100, 4'hF, 32'h0);
    issue("lw_readback", 1'b0, LS_W, 32'h100, 32'h0, 32'hBEEF_AB34, 1'b0, 3);
    drain();

    issue("illegal_d", 1'b0, LS_D, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    drain();
    issue("illegal_111", 1'b1, 3'b111, 32'h100, 32'h5, 32'h0, 1'b1, 1);
    drain();

    mem_arr[32'h100] = 32'h1122_3344;
    mem_arr[32'h104] = 32'h5566_7788;
    req_hi_cnt = 0;
`ifdef LSU_MISALIGN_SPLIT_EN
    push_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    push_beat(1'b0, 32'h104, 4'b0011, 32'h0);
    issue("lw_split", 1'b0, LS_W, 32'h102, 32'h0, 32'h7788_1122, 1'b0, 5);
    drain();
    push_beat(1'b0, 32'h100, 4'b0110, 32'h0);
    issue("lh_inword", 1'b0, LS_H, 32'h101, 32'h0, 32'h0000_2233, 1'b0, 3);
    drain();
    push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    push_beat(1'b0, 32'h104, 4'b0001, 32'h0);
    issue("lh_split", 1'b0, LS_H, 32'h103, 32'h0, 32'hFFFF_8811, 1'b0, 5);
    drain();
`else
    issue("lw_misaligned", 1'b0, LS_W, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    drain();
    issue("lh_misaligned", 1'b0, LS_H, 32'h101, 32'h0, 32'h0, 1'b1, 1);
    drain();
    issue("sh_misaligned", 1'b1, LS_H, 32'h103, 32'h1234, 32'h0, 1'b1, 1);
    drain();
    chk("misaligned_no_mem_req", req_hi_cnt, 32'd0);
`endif

    gnt_en = 1'b0;
    req_hi_cnt = 0;
    issue("timeout_gnt", 1'b0, LS_W, 32'h100, 32'h0, 32'h0, 1'b1, 5);
    drain();
    chk("timeout_mem_req_cycles", req_hi_cnt, 32'd4);
    gnt_en = 1'b1;

    rv_en = 1'b0;
    push_beat(1'b0, 32'h100, 4'hF, 32'h0);
    issue("timeout_rvalid", 1'b0, LS_W, 32'h100, 32'h0, 32'h0, 1'b1, 6);
    drain();

    push_beat(1'b0, 32'h104, 4'hF, 32'h0);
    issue("rst_in_data", 1'b0, LS_W, 32'h104, 32'h0, 32'h0, 1'b0, -1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mid_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rv_en = 1'b1;
    drain();

    push_beat(1'b0, 32'h104, 4'hF, 32'h0);
    issue("lw_after_rst", 1'b0, LS_W, 32'h104, 32'h0, 32'h5566_7788, 1'b0, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
